// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer: walks a contiguous weight-ROM range and streams each weight out on valid/ready.
module weight_fetch_sequencer #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_enable,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_valid,
   output logic                  w_last,
   input  logic                  w_ready
);
   localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, FIN = 2'd3;
   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] remaining;
   assign busy       = state != IDLE;
   assign done       = state == FIN;
   assign rom_enable = state == FETCH;
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         remaining   <= '0;
         rom_address <= '0;
         w_data      <= '0;
         w_valid     <= 1'b0;
         w_last      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (count != '0) begin
                  rom_address <= base_addr;
                  remaining   <= count;
                  state       <= FETCH;
               end else
                  state <= FIN;
            end
            // rom_data is only trusted here, while the ROM is enabled
            FETCH: begin
               w_data  <= rom_data;
               w_valid <= 1'b1;
               w_last  <= remaining == ADDR_WIDTH'(1);
               state   <= HOLD;
            end
            HOLD: if (w_ready) begin
               w_valid   <= 1'b0;
               w_last    <= 1'b0;
               remaining <= remaining - 1'b1;
               if (w_last)
                  state <= FIN;
               else begin
                  rom_address <= rom_address + 1'b1;
                  state       <= FETCH;
               end
            end
            FIN: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/weight_fetch_sequencer.md
Name: weight_fetch_sequencer

Overview:
Read-side initiator for the weight ROM. On a start command it walks a contiguous range of ROM addresses and drives the ROM address/enable pins. It samples each returned weight and presents it to the neuron datapath on a valid/ready stream, marking the last weight. It sits between the network control FSM (start/done) and the MAC/neuron units (weight stream).

Parameters:
ADDR_WIDTH, 8, width of ROM address, base_addr and count.
DATA_WIDTH, 8, width of a weight word.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request; sampled only in IDLE.
base_addr  input  ADDR_WIDTH  first ROM address, latched on accepted start.
count  input  ADDR_WIDTH  number of weights to fetch, latched on accepted start; 0 is legal.
busy  output  1  high from the cycle after an accepted start until the cycle after done.
done  output  1  one-cycle pulse when the burst completes.
rom_address  output  ADDR_WIDTH  address to the ROM.
rom_enable  output  1  ROM output enable. The ROM data bus is only meaningful while this is high.
rom_data  input  DATA_WIDTH  combinational ROM read data; may be Z/X when rom_enable is low.
w_data  output  DATA_WIDTH  registered weight.
w_valid  output  1  w_data is valid.
w_last  output  1  qualifies the final weight of the burst; meaningful only with w_valid.
w_ready  input  1  downstream accepts w_data when w_valid and w_ready are both high at a clock edge.

Behaviour:
- Reset (synchronous, highest priority), effective at the next edge:
  - State goes to IDLE.
  - busy, done, rom_enable, w_valid and w_last are all 0.
  - rom_address, w_data and the internal counters are 0.
  - A reset in mid-burst abandons the burst, produces no done pulse, and leaves no stale w_valid.
- States: IDLE, FETCH, HOLD, FIN. All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE:
  - rom_enable=0, w_valid=0.
  - start=1 with count!=0: latch base_addr into rom_address, set remaining=count, go to FETCH, busy=1.
  - start=1 with count==0: go to FIN without touching the ROM.
- FETCH (exactly one cycle):
  - rom_enable=1 and rom_address is stable.
  - At the edge: w_data<=rom_data, w_valid<=1, w_last<=(remaining==1), go to HOLD.
  - rom_enable drops to 0 in HOLD.
- HOLD:
  - w_valid=1; w_data and w_last are held stable until the handshake.
  - On w_valid&&w_ready at an edge: w_valid<=0; remaining<=remaining-1.
  - If w_last was set: go to FIN.
  - Otherwise: rom_address<=rom_address+1 (modulo 2^ADDR_WIDTH, so 8'hFF wraps to 8'h00) and go to FETCH.
- FIN (one cycle): done=1, busy=1. Then return to IDLE, where busy=0 and done=0.
- Latency and throughput:
  - An accepted start at edge k puts rom_enable high during cycle k..k+1.
  - The first w_valid is high after edge k+1.
  - Peak throughput is 1 weight per 2 cycles with w_ready held high.
  - done rises the cycle after the last handshake.
- start is ignored in FETCH, HOLD and FIN; it is not queued. base_addr and count are don't-care outside an accepted start.
- rom_data is sampled only at the FETCH edge. Z/X on rom_data in any other cycle must never propagate to w_data.
- Maximum burst is count=2^ADDR_WIDTH-1 (255). remaining is ADDR_WIDTH bits wide.

Test Plan:
- The bench ROM model holds the repeating pattern 1,3,2,5,6,5,5,2 (address mod 8) and drives Z when not enabled.
- Basic burst: base_addr=0, count=4, w_ready=1.
  - Required: rom_address sequence 0,1,2,3 with one rom_enable cycle each.
  - Stream 1,3,2,5, with w_last only on the 5.
  - done pulses once, one cycle after the 4th handshake; busy is high for exactly 9 cycles.
- Backpressure: base_addr=4, count=3; w_ready low for 5 cycles on the 2nd weight.
  - Required: w_data=5 and w_valid held stable throughout the stall, with no extra rom_enable cycles.
  - Stream 6,5,5, w_last on the final 5.
- Wrap-around: base_addr=8'hFE, count=4.
  - Required: addresses FE,FF,00,01; stream 5,2,1,3; done once.
- Zero count: start with count=0.
  - Required: rom_enable never asserts and w_valid never asserts.
  - done pulses for exactly 1 cycle, 2 edges after start.
- Start while busy, then reset mid-burst:
  - Start base_addr=0, count=8. Pulse start with base_addr=16 during HOLD of weight 2: required, it is ignored and the stream continues with address 2.
  - Assert reset during the 5th FETCH: required, next cycle has busy=0, w_valid=0, rom_enable=0, and no done pulse.
  - A new start (base_addr=3, count=2) afterwards yields 5,6.
